rv32i_instr_encoder: RTL and testbench

//  Inverse of the control decoder: accepts abstract operation requests (kind, alu_op, width, regs, imm), emits

---
 rtl/rv32i_instr_encoder.sv | 146 ++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: encodes abstract RV32I operation requests and writes them sequentially into imem
module rv32i_instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [3:0]        req_alu_op,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [2:0]        req_cond,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FULL} state_t;
  state_t state_q, state_d;
  logic              wr_en_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q, nxt_q;
  logic [31:0]       wr_data_q, enc;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3;
  logic              legal, accept, alt, is_shift, imm12_ok, imm13_ok, imm21_ok, sh_ok;
  assign accept   = req_valid && req_ready;
  assign alt      = req_alu_op == 4'd1 || req_alu_op == 4'd7;
  assign is_shift = req_alu_op inside {4'd5, 4'd6, 4'd7};
  assign imm12_ok = &req_imm[31:11] || ~|req_imm[31:11];
  assign imm13_ok = &req_imm[31:12] || ~|req_imm[31:12];
  assign imm21_ok = &req_imm[31:20] || ~|req_imm[31:20];
  assign sh_ok    = ~|req_imm[31:5];
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;
  assign word_count = cnt_q;
  // alu_op to funct3 (ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU)
  always_comb begin
    case (req_alu_op)
      4'd2:       f3 = 3'b111;
      4'd3:       f3 = 3'b110;
      4'd4:       f3 = 3'b100;
      4'd5:       f3 = 3'b001;
      4'd6, 4'd7: f3 = 3'b101;
      4'd8:       f3 = 3'b010;
      4'd9:       f3 = 3'b011;
      default:    f3 = 3'b000;
    endcase
  end
  // instruction word assembly and legality check for the current request
  always_comb begin
    legal = 1'b0;
    enc   = '0;
    case (req_kind)
      3'd0: begin
        legal = req_alu_op < 4'd10;
        enc   = {1'b0, alt, 5'b0, req_rs2, req_rs1, f3, req_rd, 7'b0110011};
      end
      3'd1: begin
        legal = req_alu_op < 4'd10 && req_alu_op != 4'd1 && (is_shift ? sh_ok : imm12_ok);
        enc   = {is_shift ? {1'b0, alt, 5'b0, req_imm[4:0]} : req_imm[11:0], req_rs1, f3, req_rd, 7'b0010011};
      end
      3'd2: begin
        legal = req_width != 2'b11 && !(req_width == 2'b10 && req_unsigned) && imm12_ok;
        enc   = {req_imm[11:0], req_rs1, req_unsigned, req_width, req_rd, 7'b0000011};
      end
      3'd3: begin
        legal = req_width != 2'b11 && !req_unsigned && imm12_ok;
        enc   = {req_imm[11:5], req_rs2, req_rs1, 1'b0, req_width, req_imm[4:0], 7'b0100011};
      end
      3'd4: begin
        legal = !req_imm[0] && imm13_ok && req_cond[2:1] != 2'b01;
        enc   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_cond, req_imm[4:1], req_imm[11], 7'b1100011};
      end
      3'd5: begin
        legal = ~|req_imm[11:0];
        enc   = {req_imm[31:12], req_rd, 7'b0110111};
      end
      3'd6: begin
        legal = ~|req_imm[11:0];
        enc   = {req_imm[31:12], req_rd, 7'b0010111};
      end
      default: begin
        legal = !req_imm[0] && imm21_ok;
        enc   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
      end
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: start always restarts; the last legal word fills the program
  always_comb begin
    state_d = state_q;
    if (start) state_d = RUN;
    else if (state_q == RUN && stop) state_d = DONE;
    else if (accept && legal && cnt_q == CNT_W'(DEPTH - 1)) state_d = FULL;
  end
  // state-derived outputs; start/stop take priority over a same-cycle request
  always_comb begin
    busy      = state_q == RUN;
    full      = state_q == FULL;
    req_ready = state_q == RUN && !start && !stop;
  end
  // write port, address pointer, word counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      nxt_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else if (start) begin
      wr_en_q <= 1'b0;
      nxt_q   <= start_addr & ~ADDR_W'(3);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= accept && legal;
      if (accept && legal) begin
        wr_addr_q <= nxt_q;
        wr_data_q <= enc;
        nxt_q     <= nxt_q + ADDR_W'(4);
        cnt_q     <= cnt_q + CNT_W'(1);
      end
      if (accept && !legal) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: vector table, directed sequences and random run against a reference model
module tb_rv32i_instr_encoder;
  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  alu;
    logic [1:0]  width;
    logic        uns;
    logic [2:0]  cond;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } req_t;
  typedef struct {
    req_t        r;
    bit          ok;
    logic [31:0] w;
  } vec_t;
  logic clk = 0, rst, start, stop, req_valid, req_ready, req_unsigned;
  logic [31:0] start_addr, req_imm, wr_addr, wr_data;
  logic [2:0] req_kind, req_cond, word_count;
  logic [3:0] req_alu_op;
  logic [1:0] req_width;
  logic [4:0] req_rd, req_rs1, req_rs2;
  logic wr_en, busy, full, err;
  int total = 0, bad = 0;
  vec_t tv[$];
  int f3t[16] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3, 0, 0, 0, 0, 0, 0};
  int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 31, 32, 1048574, -1048576, 1048576, 32'h12345000, 0, -1};
  int m_mode, m_cnt;
  bit m_err;
  logic [31:0] m_next;

  rv32i_instr_encoder #(.ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .stop(stop),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_alu_op(req_alu_op),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_cond(req_cond), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .full(full), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic req_t mk(input int k, al, wd, u, c, rd, rs1, rs2, input logic [31:0] imm);
    req_t r;
    r.kind = 3'(k); r.alu = 4'(al); r.width = 2'(wd); r.uns = 1'(u); r.cond = 3'(c);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
    return r;
  endfunction

  task automatic put(input req_t r);
    req_kind = r.kind; req_alu_op = r.alu; req_width = r.width; req_unsigned = r.uns;
    req_cond = r.cond; req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
  endtask

  function automatic void add(input req_t r, input bit ok, input logic [31:0] w);
    vec_t v;
    v.r = r; v.ok = ok; v.w = w;
    tv.push_back(v);
  endfunction

  // reference encoder built from the ISA field layouts with integer arithmetic
  function automatic void ref_enc(input req_t r, output bit ok, output logic [31:0] w);
    int s, sh;
    bit in12;
    s = int'($signed(r.imm));
    in12 = s >= -2048 && s <= 2047;
    sh = r.alu inside {5, 6, 7};
    ok = 0;
    w = 0;
    case (r.kind)
      0: begin
        ok = r.alu < 10;
        w = ((r.alu == 1 || r.alu == 7) ? 32'h40000000 : 0) | 32'(r.rs2) << 20 | 32'(r.rs1) << 15
          | 32'(f3t[r.alu]) << 12 | 32'(r.rd) << 7 | 32'h33;
      end
      1: begin
        ok = r.alu < 10 && r.alu != 1 && (sh ? (s >= 0 && s <= 31) : in12);
        w = (sh ? ((r.alu == 7 ? 1024 : 0) + (s & 31)) : (s & 32'hFFF)) << 20 | 32'(r.rs1) << 15
          | 32'(f3t[r.alu]) << 12 | 32'(r.rd) << 7 | 32'h13;
      end
      2: begin
        ok = r.width != 3 && !(r.width == 2 && r.uns) && in12;
        w = (s & 32'hFFF) << 20 | 32'(r.rs1) << 15 | (32'(r.uns) * 4 + 32'(r.width)) << 12 | 32'(r.rd) << 7 | 32'h03;
      end
      3: begin
        ok = r.width != 3 && !r.uns && in12;
        w = ((s >> 5) & 127) << 25 | 32'(r.rs2) << 20 | 32'(r.rs1) << 15 | 32'(r.width) << 12 | (s & 31) << 7 | 32'h23;
      end
      4: begin
        ok = (s & 1) == 0 && s >= -4096 && s <= 4094 && r.cond != 2 && r.cond != 3;
        w = ((s >> 12) & 1) << 31 | ((s >> 5) & 63) << 25 | 32'(r.rs2) << 20 | 32'(r.rs1) << 15
          | 32'(r.cond) << 12 | ((s >> 1) & 15) << 8 | ((s >> 11) & 1) << 7 | 32'h63;
      end
      5, 6: begin
        ok = (s & 32'hFFF) == 0;
        w = (s & 32'hFFFFF000) | 32'(r.rd) << 7 | (r.kind == 5 ? 32'h37 : 32'h17);
      end
      default: begin
        ok = (s & 1) == 0 && s >= -1048576 && s <= 1048575;
        w = ((s >> 20) & 1) << 31 | ((s >> 1) & 1023) << 21 | ((s >> 11) & 1) << 20
          | ((s >> 12) & 255) << 12 | 32'(r.rd) << 7 | 32'h6F;
      end
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int c;
    r = mk($urandom_range(0, 7), $urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0);
    c = $urandom_range(0, 5);
    r.imm = c == 0 ? 32'(int'($urandom_range(0, 48)) - 8) :
            c == 1 ? 32'(bnd[$urandom_range(0, 15)]) :
            c == 2 ? 32'($urandom) :
            c == 3 ? 32'($urandom) & 32'hFFFFF000 :
            c == 4 ? 32'(int'($urandom_range(0, 8190)) - 4096) & ~32'h1 :
                     32'(int'($urandom_range(0, 2097150)) - 1048576) & ~32'h1;
    return r;
  endfunction

  initial begin
    req_t q;
    bit ok, st, sp, v, exp_ready, exp_wr;
    logic [31:0] we, ea;
    int rn;
    rst = 1; start = 0; stop = 0; req_valid = 0; start_addr = 0;
    put(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick; tick;
    chk("rst_wr_en", wr_en, 0); chk("rst_wr_addr", wr_addr, 0); chk("rst_wr_data", wr_data, 0);
    chk("rst_err", err, 0); chk("rst_count", word_count, 0); chk("rst_busy", busy, 0);
    chk("rst_full", full, 0); chk("rst_ready", req_ready, 0);
    rst = 0;
    add(mk(0, 0, 0, 0, 0, 3, 1, 2, 0), 1, 32'h002081B3);
    add(mk(1, 0, 0, 0, 0, 1, 0, 0, -1), 1, 32'hFFF00093);
    add(mk(3, 0, 2, 0, 0, 0, 1, 2, 8), 1, 32'h0020A423);
    add(mk(4, 0, 0, 0, 0, 0, 1, 2, -4), 1, 32'hFE208EE3);
    add(mk(5, 0, 0, 0, 0, 5, 0, 0, 32'h12345000), 1, 32'h123452B7);
    add(mk(1, 7, 0, 0, 0, 1, 1, 0, 3), 1, 32'h4030D093);
    add(mk(0, 1, 0, 0, 0, 5, 6, 7, 0), 1, 32'h407302B3);
    add(mk(2, 0, 0, 1, 0, 4, 2, 0, -1), 1, 32'hFFF14203);
    add(mk(7, 0, 0, 0, 0, 1, 0, 0, 8), 1, 32'h008000EF);
    add(mk(6, 0, 0, 0, 0, 10, 0, 0, 32'h1000), 1, 32'h00001517);
    add(mk(4, 0, 0, 0, 4, 0, 0, 0, -4096), 1, 32'h80004063);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 2047), 1, 32'h7FF00013);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, -2048), 1, 32'h80000013);
    add(mk(1, 0, 0, 0, 0, 1, 0, 0, 2048), 0, 0);
    add(mk(1, 1, 0, 0, 0, 1, 0, 0, 1), 0, 0);
    add(mk(1, 5, 0, 0, 0, 1, 0, 0, 32), 0, 0);
    add(mk(2, 0, 3, 0, 0, 1, 0, 0, 0), 0, 0);
    add(mk(2, 0, 2, 1, 0, 1, 0, 0, 0), 0, 0);
    add(mk(3, 0, 0, 1, 0, 1, 0, 0, 0), 0, 0);
    add(mk(4, 0, 0, 0, 2, 0, 1, 2, 8), 0, 0);
    add(mk(4, 0, 0, 0, 0, 0, 1, 2, 5), 0, 0);
    add(mk(4, 0, 0, 0, 0, 0, 1, 2, 4096), 0, 0);
    add(mk(7, 0, 0, 0, 0, 1, 0, 0, 7), 0, 0);
    add(mk(5, 0, 0, 0, 0, 1, 0, 0, 32'h123), 0, 0);
    add(mk(0, 10, 0, 0, 0, 1, 2, 3, 0), 0, 0);
    foreach (tv[i]) begin
      start = 1; start_addr = 32'h200;
      tick;
      start = 0; put(tv[i].r); req_valid = 1;
      #1 chk($sformatf("vec%0d_ready", i), req_ready, 1);
      tick;
      req_valid = 0;
      chk($sformatf("vec%0d_wr_en", i), wr_en, tv[i].ok);
      chk($sformatf("vec%0d_err", i), err, !tv[i].ok);
      if (tv[i].ok) begin
        chk($sformatf("vec%0d_data", i), wr_data, tv[i].w);
        chk($sformatf("vec%0d_addr", i), wr_addr, 32'h200);
      end
    end
    // back-to-back writes from 0x100
    start = 1; start_addr = 32'h103;
    tick;
    start = 0; put(mk(1, 0, 0, 0, 0, 1, 0, 0, -1)); req_valid = 1;
    tick;
    chk("b2b_en0", wr_en, 1); chk("b2b_addr0", wr_addr, 32'h100); chk("b2b_data0", wr_data, 32'hFFF00093);
    put(mk(3, 0, 2, 0, 0, 0, 1, 2, 8));
    tick;
    req_valid = 0;
    chk("b2b_en1", wr_en, 1); chk("b2b_addr1", wr_addr, 32'h104); chk("b2b_data1", wr_data, 32'h0020A423);
    chk("b2b_cnt", word_count, 2);
    tick;
    chk("b2b_idle", wr_en, 0);
    // illegal request leaves address and count alone
    put(mk(1, 0, 0, 0, 0, 1, 0, 0, 2048)); req_valid = 1;
    tick;
    chk("ill_en", wr_en, 0); chk("ill_err", err, 1); chk("ill_cnt", word_count, 2);
    put(mk(0, 0, 0, 0, 0, 3, 1, 2, 0));
    tick;
    req_valid = 0;
    chk("ill_next_en", wr_en, 1); chk("ill_next_addr", wr_addr, 32'h108); chk("ill_next_err", err, 1);
    chk("ill_next_cnt", word_count, 3);
    // fill to DEPTH, then restart with a colliding request
    start = 1; start_addr = 32'h300;
    tick;
    start = 0; req_valid = 1;
    for (int k = 0; k < 4; k++) tick;
    chk("full_en", wr_en, 1); chk("full_addr", wr_addr, 32'h30C); chk("full_flag", full, 1);
    chk("full_cnt", word_count, 4); chk("full_busy", busy, 0);
    #1 chk("full_ready", req_ready, 0);
    tick;
    chk("full_hold", wr_en, 0); chk("full_hold_cnt", word_count, 4);
    start = 1;
    #1 chk("startreq_ready", req_ready, 0);
    tick;
    start = 0; req_valid = 0;
    chk("restart_cnt", word_count, 0); chk("restart_err", err, 0); chk("restart_busy", busy, 1);
    chk("restart_full", full, 0); chk("startreq_en", wr_en, 0);
    // reset right after an accept
    req_valid = 1;
    tick;
    req_valid = 0; rst = 1;
    chk("rstmid_pending", wr_en, 1);
    tick;
    rst = 0;
    chk("rstmid_en", wr_en, 0); chk("rstmid_busy", busy, 0); chk("rstmid_cnt", word_count, 0);
    chk("rstmid_addr", wr_addr, 0);
    // stop then request
    start = 1; start_addr = 32'h0;
    tick;
    start = 0; stop = 1;
    tick;
    stop = 0; req_valid = 1;
    #1 chk("stop_ready", req_ready, 0);
    tick;
    req_valid = 0;
    chk("stop_en", wr_en, 0); chk("stop_busy", busy, 0); chk("stop_cnt", word_count, 0);
    // random run against the reference model
    rst = 1;
    tick;
    rst = 0; m_mode = 0; m_cnt = 0; m_err = 0; m_next = 0; ea = 0;
    for (int c = 0; c < 1500; c++) begin
      rn = $urandom_range(0, 99);
      q = rand_req();
      st = rn < 5 || (m_mode != 1 && rn < 30);
      sp = !st && rn >= 5 && rn < 9;
      v = $urandom_range(0, 4) != 0;
      start = st; stop = sp; req_valid = v; put(q);
      start_addr = $urandom_range(0, 3) == 0 ? (32'hFFFFFFF4 | 32'($urandom_range(0, 3))) : 32'($urandom);
      #1;
      exp_ready = m_mode == 1 && !st && !sp;
      chk("rnd_ready", req_ready, exp_ready);
      ref_enc(q, ok, we);
      exp_wr = 0;
      if (st) begin
        m_mode = 1; m_next = start_addr & ~32'h3; m_cnt = 0; m_err = 0;
      end else if (sp && m_mode == 1) m_mode = 2;
      else if (v && exp_ready) begin
        if (ok) begin
          exp_wr = 1; ea = m_next; m_next += 4; m_cnt++;
          if (m_cnt == 4) m_mode = 3;
        end else m_err = 1;
      end
      tick;
      chk("rnd_wr_en", wr_en, exp_wr);
      if (exp_wr) begin
        chk("rnd_addr", wr_addr, ea);
        chk("rnd_data", wr_data, we);
      end
      chk("rnd_err", err, m_err); chk("rnd_cnt", word_count, m_cnt);
      chk("rnd_busy", busy, m_mode == 1); chk("rnd_full", full, m_mode == 3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
